// File: rtl/conv_mac_sequencer.sv
// Drives a shared signed 8x8 MAC to convolve a streaming sample window with KSIZE coefficients.
// Optional build macro RELU_EN clamps negative results to zero at capture.
module conv_mac_sequencer #(
    parameter int unsigned KSIZE = 9,
    parameter int unsigned AW    = $clog2(KSIZE)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          CoefWrEn,
    input  logic [AW-1:0] CoefAddr,
    input  logic [7:0]    CoefData,
    output logic          CoefDrop,
    input  logic          Flush,
    input  logic          SampleValid,
    output logic          SampleReady,
    input  logic [7:0]    SampleData,
    output logic [7:0]    MacX,
    output logic [7:0]    MacY,
    output logic          MacAccumReset,
    input  logic [31:0]   MacHolder,
    output logic          ResultValid,
    input  logic          ResultReady,
    output logic [31:0]   ResultData
);

    localparam int unsigned FW = $clog2(KSIZE + 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(KSIZE);
    localparam logic [FW-1:0] FILL_TRIG = FW'(KSIZE - 1);
    localparam logic [AW-1:0] LAST_TAP  = AW'(KSIZE - 1);
    localparam logic [AW:0]   NUM_TAPS  = (AW + 1)'(KSIZE);

    typedef enum logic [1:0] {StIdle, StClear, StMac, StCapture} state_e;

    state_e        state;
    logic [7:0]    win  [KSIZE];
    logic [7:0]    coef [KSIZE];
    logic [FW-1:0] fill;
    logic [AW-1:0] tap;
    logic          accept;
    logic          coef_ok;

    assign SampleReady = (state == StIdle) && !ResultValid;
    assign accept      = SampleReady && SampleValid && !Flush;
    assign coef_ok     = (state == StIdle) && ({1'b0, CoefAddr} < NUM_TAPS);
    assign MacX        = (state == StMac) ? win[tap]  : 8'd0;
    assign MacY        = (state == StMac) ? coef[tap] : 8'd0;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state         <= StIdle;
            fill          <= '0;
            tap           <= '0;
            CoefDrop      <= 1'b0;
            MacAccumReset <= 1'b0;
            ResultValid   <= 1'b0;
            ResultData    <= '0;
            for (int i = 0; i < KSIZE; i++) begin
                win[i]  <= '0;
                coef[i] <= '0;
            end
        end else begin
            if (CoefWrEn) begin
                if (coef_ok) coef[CoefAddr] <= CoefData;
                else         CoefDrop       <= 1'b1;
            end
            if (ResultValid && ResultReady) ResultValid <= 1'b0;
            MacAccumReset <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (Flush) begin
                        fill <= '0;
                    end else if (accept) begin
                        for (int i = 0; i < KSIZE - 1; i++) win[i] <= win[i+1];
                        win[KSIZE-1] <= SampleData;
                        if (fill != FILL_MAX) fill <= fill + FW'(1);
                        // Window is complete once this sample lands
                        if (fill >= FILL_TRIG) begin
                            state         <= StClear;
                            MacAccumReset <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    tap   <= '0;
                    state <= StMac;
                end
                StMac: begin
                    if (tap == LAST_TAP) state <= StCapture;
                    else                 tap   <= tap + AW'(1);
                end
                StCapture: begin
`ifdef RELU_EN
                    ResultData <= MacHolder[31] ? 32'd0 : MacHolder;
`else
                    ResultData <= MacHolder;
`endif
                    ResultValid <= 1'b1;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer with KSIZE=3, a behavioural MAC and a queue-based dot-product model.
module tb_conv_mac_sequencer;

    localparam int K = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coef_wr_en;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        coef_drop;
    logic        flush;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  sample_data;
    logic [7:0]  mac_x;
    logic [7:0]  mac_y;
    logic        mac_accum_reset;
    logic [31:0] mac_holder;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;

    int checks   = 0;
    int failures = 0;

    int m_coef [K];
    int m_win  [$];

    always #5 clk = ~clk;

    conv_mac_sequencer #(.KSIZE(K)) dut (
        .Clk           (clk),
        .Reset_n       (rst_n),
        .CoefWrEn      (coef_wr_en),
        .CoefAddr      (coef_addr),
        .CoefData      (coef_data),
        .CoefDrop      (coef_drop),
        .Flush         (flush),
        .SampleValid   (sample_valid),
        .SampleReady   (sample_ready),
        .SampleData    (sample_data),
        .MacX          (mac_x),
        .MacY          (mac_y),
        .MacAccumReset (mac_accum_reset),
        .MacHolder     (mac_holder),
        .ResultValid   (result_valid),
        .ResultReady   (result_ready),
        .ResultData    (result_data)
    );

    // Shared MAC unit
    logic signed [15:0] prod;
    logic signed [31:0] acc;
    assign prod       = $signed(mac_x) * $signed(mac_y);
    assign mac_holder = acc;
    always @(posedge clk) begin
        if (mac_accum_reset) acc <= 32'sd0;
        else                 acc <= acc + {{16{prod[15]}}, prod};
    end

    function automatic logic [31:0] model_result();
        int s = 0;
        for (int i = 0; i < m_win.size(); i++) s += m_coef[i] * m_win[i];
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return 32'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input int d);
        coef_wr_en = 1'b1;
        coef_addr  = 2'(a);
        coef_data  = 8'(d);
        tick();
        coef_wr_en = 1'b0;
        if (a < K) m_coef[a] = d;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_win.delete();
    endtask

    task automatic send(input int d);
        int n = 0;
        while (!sample_ready && n < 30) begin
            tick();
            n++;
        end
        check("send_ready", {31'd0, sample_ready}, 32'd1);
        sample_valid = 1'b1;
        sample_data  = 8'(d);
        tick();
        sample_valid = 1'b0;
        m_win.push_back(d);
        if (m_win.size() > K) void'(m_win.pop_front());
    endtask

    task automatic expect_result(input string tag, input int n0, input bit take);
        int n = n0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(K + 2));
        check({tag, "_data"}, result_data, model_result());
        if (take) begin
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            check({tag, "_valid_fall"}, {31'd0, result_valid}, 32'd0);
        end
    endtask

    task automatic expect_none(input string tag);
        bit seen = 1'b0;
        repeat (8) begin
            tick();
            if (result_valid) seen = 1'b1;
        end
        check({tag, "_no_result"}, {31'd0, seen}, 32'd0);
        check({tag, "_ready"}, {31'd0, sample_ready}, 32'd1);
    endtask

    task automatic feed(input int d, input string tag);
        send(d);
        if (m_win.size() == K) expect_result(tag, 0, 1'b1);
        else                   expect_none(tag);
    endtask

    initial begin
        int bad;
        rst_n        = 1'b0;
        coef_wr_en   = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;
        flush        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        result_ready = 1'b0;
        for (int i = 0; i < K; i++) m_coef[i] = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_data", result_data, 32'd0);
        check("rst_sready", {31'd0, sample_ready}, 32'd1);
        check("rst_drop", {31'd0, coef_drop}, 32'd0);
        check("rst_accrst", {31'd0, mac_accum_reset}, 32'd0);
        check("rst_macxy", {16'd0, mac_x, mac_y}, 32'd0);

        // 1: partial window then first full window
        write_coef(0, 1);
        write_coef(1, 2);
        write_coef(2, 3);
        feed(1, "t1_s1");
        feed(2, "t1_s2");
        feed(3, "t1_s3");
        check("t1_const", result_data, 32'd14);

        // 2: MAC drive sequence for window {2,3,4}
        send(4);
        check("t2_clear_rst", {31'd0, mac_accum_reset}, 32'd1);
        check("t2_clear_xy", {16'd0, mac_x, mac_y}, 32'd0);
        for (int i = 0; i < K; i++) begin
            tick();
            check("t2_tap_rst", {31'd0, mac_accum_reset}, 32'd0);
            check("t2_tap_xy", {16'd0, mac_x, mac_y}, {16'd0, 8'(i + 2), 8'(i + 1)});
        end
        tick();
        check("t2_capture_xy", {16'd0, mac_x, mac_y}, 32'd0);
        expect_result("t2", K + 1, 1'b1);
        check("t2_const", result_data, 32'd20);

        // 3: extreme operands and negative sums
        do_flush();
        write_coef(0, -128);
        write_coef(1, 0);
        write_coef(2, 0);
        feed(-128, "t3a_s1");
        feed(0, "t3a_s2");
        feed(0, "t3a_s3");
        check("t3a_const", result_data, 32'h0000_4000);
        write_coef(0, 1);
        write_coef(1, 1);
        write_coef(2, 1);
        do_flush();
        feed(-1, "t3b_s1");
        feed(-2, "t3b_s2");
        feed(-3, "t3b_s3");
`ifdef RELU_EN
        check("t3b_const", result_data, 32'd0);
`else
        check("t3b_const", result_data, 32'hFFFF_FFFA);
`endif

        // 4: back-pressure on the result port
        send(-4);
        expect_result("t4", 0, 1'b0);
        bad = 0;
        repeat (10) begin
            tick();
            if (result_valid !== 1'b1 || result_data !== model_result() || sample_ready !== 1'b0)
                bad++;
        end
        check("t4_hold", 32'(bad), 32'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("t4_fall", {31'd0, result_valid}, 32'd0);

        // 5: dropped coefficient writes, flush behaviour
        send(5);
        tick();
        coef_wr_en = 1'b1;
        coef_addr  = 2'd0;
        coef_data  = 8'd99;
        tick();
        coef_wr_en = 1'b0;
        check("t5_drop_mac", {31'd0, coef_drop}, 32'd1);
        expect_result("t5_mac_wr", 2, 1'b1);
        write_coef(3, 77);
        check("t5_drop_addr", {31'd0, coef_drop}, 32'd1);
        feed(6, "t5_after_addr");
        flush        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 8'd50;
        tick();
        flush        = 1'b0;
        sample_valid = 1'b0;
        m_win.delete();
        feed(7, "t5_f1");
        feed(8, "t5_f2");
        feed(9, "t5_f3");
        check("t5_const", result_data, 32'd24);

        // 6: reset in the middle of a window
        send(10);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < K; i++) m_coef[i] = 0;
        m_win.delete();
        check("t6_sready", {31'd0, sample_ready}, 32'd1);
        check("t6_valid", {31'd0, result_valid}, 32'd0);
        check("t6_data", result_data, 32'd0);
        check("t6_macxy", {16'd0, mac_x, mac_y}, 32'd0);
        check("t6_accrst", {31'd0, mac_accum_reset}, 32'd0);
        check("t6_drop", {31'd0, coef_drop}, 32'd0);
        expect_none("t6_idle");
        feed(11, "t6_s1");
        feed(-12, "t6_s2");
        feed(13, "t6_s3");
        check("t6_const", result_data, 32'd0);

        // Randomized windows against the model
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < K; a++) write_coef(a, int'($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 2) == 0) do_flush();
            for (int s = 0; s < int'($urandom_range(1, 4)); s++)
                feed(int'($urandom_range(0, 255)) - 128, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
